cdc_2phase_clear_seq: RTL
=========================

// Module: cdc_2phase_clear_seq
// PURPOSE
//  Clear initiator for the source side of the clearable 2-phase CDC.
//  Sits between the upstream producer and the CDC source port.
//  On request it quiesces traffic, optionally drains the in-flight item, pulses the CDC clear,
//  then tracks the clear-pending window to completion and reports status.
//  Guarantees the CDC rule "no valid while clear" by construction.
// PARAMETERS
//  T              logic  payload type, passed through unmodified
//  DRAIN_EN       1      1: wait for in-flight item ack before clearing; 0: clear at once
//  DRAIN_CYCLES   64     max DRAIN wait before forced clear (>=1)
//  TIMEOUT_CYCLES 256    max wait for clear-pending to rise, and separately to fall (>=2)
// PORTS
//  clk_i               in   1      clock
//  rst_ni              in   1      synchronous active-low reset
//  clear_req_i         in   1      level; start clear sequence when sampled high in IDLE
//  busy_o              out  1      sequence in progress (state != IDLE)
//  done_o              out  1      1-cycle pulse at sequence end
//  err_o               out  2      [0] drain timeout, [1] pending timeout; sticky until next start
//  data_i / valid_i    in   T / 1  upstream payload / valid
//  ready_o             out  1      upstream ready
//  cdc_data_o          out  T      = data_i (combinational)
//  cdc_valid_o         out  1      to CDC src_valid_i
//  cdc_ready_i         in   1      from CDC src_ready_o
//  cdc_clear_o         out  1      to CDC src_clear_i
//  cdc_clear_pending_i in   1      from CDC src_clear_pending_o
// BEHAVIOUR
//  Reset: rst_ni low at posedge -> state IDLE, counter 0, err_o 0.
//   Next cycle: busy_o 0, done_o 0, cdc_clear_o 0.
//  Reset mid-sequence: abort to IDLE, no done_o pulse, cdc_clear_o low from next cycle.
//  FSM (registered state; outputs decoded from state):
//   IDLE:
//    - Passthrough: cdc_valid_o = valid_i & ~cdc_clear_pending_i;
//      ready_o = cdc_ready_i & ~cdc_clear_pending_i.
//    - clear_req_i=1 -> DRAIN if DRAIN_EN, else ISSUE. Clear err_o and counter.
//    - Handshake in the request cycle still completes.
//   DRAIN:
//    - valid/ready gated 0.
//    - cdc_ready_i=1 -> ISSUE.
//    - Else, on counter == DRAIN_CYCLES-1: set err_o[0], -> ISSUE.
//   ISSUE:
//    - cdc_clear_o=1 for exactly this cycle, gated 0.
//    - -> WAIT_RISE.
//   WAIT_RISE:
//    - cdc_clear_pending_i=1 -> WAIT_FALL.
//    - Counter == TIMEOUT_CYCLES-1: set err_o[1], -> DONE.
//   WAIT_FALL:
//    - cdc_clear_pending_i=0 -> DONE.
//    - Counter == TIMEOUT_CYCLES-1: set err_o[1], -> DONE.
//   DONE:
//    - done_o=1, gated 0.
//    - -> IDLE.
//  Gating: in every state except IDLE, cdc_valid_o=0 and ready_o=0.
//  Counter: one shared counter, width $clog2(max(DRAIN_CYCLES,TIMEOUT_CYCLES))+1.
//   Zeroed on every state change; saturates, never wraps.
//  Boundaries:
//   - Pending already high on WAIT_RISE entry: advances next cycle.
//   - clear_req_i held high: a new sequence starts the cycle after DONE.
//   - Peer-initiated clear (pending rises in IDLE): passthrough gated, no state change, no done_o.
//   - clear_req_i changes while busy: ignored.
// STRUCTURE
//  cdc_clear_seq_pkg: state_e {IDLE,DRAIN,ISSUE,WAIT_RISE,WAIT_FALL,DONE},
//   ERR_DRAIN=0, ERR_PEND=1 bit indices.
//  Single module; no sub-module (counter inline).
//  ~150-200 lines RTL + SVA: cdc_clear_o |-> !cdc_valid_o; $onehot0 pulse on done_o.
// TESTING
//  1 DRAIN_EN=1, cdc_ready_i=1, req at t0:
//    DRAIN t1, cdc_clear_o t2, pending 1 at t5, 0 at t9 -> done_o t10, err_o=0.
//  2 DRAIN_EN=1, cdc_ready_i=0 forever, DRAIN_CYCLES=4:
//    cdc_clear_o exactly 4 cycles after DRAIN entry, err_o=2'b01 at done.
//  3 pending never rises, TIMEOUT_CYCLES=8:
//    done_o 8 cycles after WAIT_RISE entry, err_o=2'b10, cdc_valid_o=0 throughout.
//  4 valid_i=1 continuous during sequence:
//    cdc_valid_o=0 and ready_o=0 from cycle after req until IDLE; never with cdc_clear_o.
//  5 rst_ni low during WAIT_FALL:
//    IDLE next cycle, no done_o, busy_o=0, err_o=0.
//  6 peer clear: pending high 5 cycles in IDLE, valid_i=1:
//    cdc_valid_o=0 for those 5 cycles, busy_o=0, no done_o.

Source files
------------

// File: rtl/cdc_clear_seq_pkg.sv
// Shared definitions for the clearable 2-phase CDC clear initiator.
//  state_e   : sequencer states
//  ERR_DRAIN : err_o bit set when the in-flight item was not acked in time
//  ERR_PEND  : err_o bit set when clear-pending failed to rise or to fall in time
//  max_int   : helper used to size the shared wait counter
package cdc_clear_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DRAIN     = 3'd1,
        ISSUE     = 3'd2,
        WAIT_RISE = 3'd3,
        WAIT_FALL = 3'd4,
        DONE      = 3'd5
    } state_e;

    localparam int ERR_DRAIN = 0;
    localparam int ERR_PEND  = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cdc_2phase_clear_seq.sv
// Clear initiator for the source side of a clearable 2-phase CDC.
// Sits between an upstream producer and the CDC source port. On request it
// blocks new traffic, optionally waits for the in-flight item to be acked,
// pulses the CDC clear for one cycle, then follows the clear-pending window
// until it closes (or times out) and reports the outcome.
//
// Ports
//  clk_i, rst_ni        clock, synchronous active-low reset
//  clear_req_i          level request, acted on only while idle
//  busy_o               sequence in progress
//  done_o               one-cycle pulse at the end of a sequence
//  err_o[1:0]           [0] drain timeout, [1] pending timeout; sticky until next start
//  data_i/valid_i       upstream payload / valid
//  ready_o              upstream ready
//  cdc_data_o           combinational copy of data_i
//  cdc_valid_o          to CDC src_valid_i
//  cdc_ready_i          from CDC src_ready_o
//  cdc_clear_o          to CDC src_clear_i
//  cdc_clear_pending_i  from CDC src_clear_pending_o
module cdc_2phase_clear_seq
    import cdc_clear_seq_pkg::*;
#(
    parameter type         T              = logic,
    parameter bit          DRAIN_EN       = 1'b1,
    parameter int unsigned DRAIN_CYCLES   = 64,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_req_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [1:0] err_o,
    input  T           data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output T           cdc_data_o,
    output logic       cdc_valid_o,
    input  logic       cdc_ready_i,
    output logic       cdc_clear_o,
    input  logic       cdc_clear_pending_i
);

    localparam int CNT_W = $clog2(max_int(int'(DRAIN_CYCLES), int'(TIMEOUT_CYCLES))) + 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       err_q, err_set;
    logic             idle, start;

    assign idle  = (state_q == IDLE);
    assign start = idle & clear_req_i;

    always_comb begin
        state_d = state_q;
        err_set = '0;
        unique case (state_q)
            IDLE: begin
                if (clear_req_i) begin
                    if (DRAIN_EN) state_d = DRAIN;
                    else          state_d = ISSUE;
                end
            end
            DRAIN: begin
                // An ack wins over the timeout when both land in the same cycle.
                if (cdc_ready_i) begin
                    state_d = ISSUE;
                end else if (cnt_q == DRAIN_LAST) begin
                    err_set[ERR_DRAIN] = 1'b1;
                    state_d            = ISSUE;
                end
            end
            ISSUE: state_d = WAIT_RISE;
            WAIT_RISE: begin
                if (cdc_clear_pending_i) begin
                    state_d = WAIT_FALL;
                end else if (cnt_q == TMO_LAST) begin
                    err_set[ERR_PEND] = 1'b1;
                    state_d           = DONE;
                end
            end
            WAIT_FALL: begin
                if (!cdc_clear_pending_i) begin
                    state_d = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    err_set[ERR_PEND] = 1'b1;
                    state_d           = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            // One counter serves every wait state; it restarts on each state
            // change and sticks at all-ones instead of wrapping.
            if (state_d != state_q)  cnt_q <= '0;
            else if (cnt_q != '1)    cnt_q <= cnt_q + CNT_W'(1);
            if (start) err_q <= '0;
            else       err_q <= err_q | err_set;
        end
    end

    // Traffic only flows while idle, and a peer-initiated clear (pending
    // high while idle) blocks it too, so valid can never coincide with clear.
    assign cdc_data_o  = data_i;
    assign cdc_valid_o = idle & valid_i & ~cdc_clear_pending_i;
    assign ready_o     = idle & cdc_ready_i & ~cdc_clear_pending_i;
    assign cdc_clear_o = (state_q == ISSUE);
    assign done_o      = (state_q == DONE);
    assign busy_o      = ~idle;
    assign err_o       = err_q;

    a_clear_no_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cdc_clear_o |-> !cdc_valid_o);
    a_done_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
        done_o |=> !done_o);

endmodule
